// File: rtl/fir_cmem_pkg.sv
// Shared types and defaults for the W4823 FIR coefficient memory and tap sequencer.
// The parity helper is used only when W4823_CMEM_PARITY_EN is defined.
package fir_cmem_pkg;

  localparam int NTAPS_DEF = 64;
  localparam int AW_DEF    = 6;
  localparam int CW_DEF    = 17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } cmem_state_e;

  // Even parity over a word zero-extended to 32 bits; XOR of all bits.
  function automatic logic even_par(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/fir_cmem_if.sv
// CMEM write port plus coefficient stream towards the MAC.
// slave = coefficient memory/sequencer side, master = host and MAC side.
interface fir_cmem_if #(
  parameter int AW = fir_cmem_pkg::AW_DEF,
  parameter int CW = fir_cmem_pkg::CW_DEF
) ();

  logic          cload;
  logic [AW-1:0] caddr;
  logic [CW-1:0] cin;
  logic          coef_valid;
  logic          coef_ready;
  logic [CW-1:0] coef_data;
  logic [AW-1:0] coef_idx;
  logic          coef_last;

  modport slave (
    input  cload, caddr, cin, coef_ready,
    output coef_valid, coef_data, coef_idx, coef_last
  );

  modport master (
    output cload, caddr, cin, coef_ready,
    input  coef_valid, coef_data, coef_idx, coef_last
  );

endinterface

// File: rtl/fir_cmem_ram.sv
// Coefficient storage: one write port, one registered read port, read-before-write.
// The read register holds its value while re is low, so it doubles as the stream output register.
module fir_cmem_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int WW    = 17
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [WW-1:0] wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [WW-1:0] rd
);

  logic [WW-1:0] mem [DEPTH];
  logic [WW-1:0] rd_d;
  logic [WW-1:0] rd_q;

  always_comb begin
    rd_d = rd_q;
    if (re) rd_d = mem[ra];
  end

  // mem[ra] is sampled before the same-edge write lands, giving the old word on a collision.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    rd_q <= rd_d;
  end

  assign rd = rd_q;

endmodule

// File: rtl/fir_cmem_seq.sv
// Coefficient memory and tap sequencer: stores NTAPS words and streams them per start strobe.
// Optional parity protection with sticky par_err when W4823_CMEM_PARITY_EN is defined.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   S_IDLE   | waiting for start; busy=0
//   S_RUN    | issuing reads 0..NTAPS-1 as the output register frees up
//   S_DRAIN  | last read issued; waiting for the MAC to accept coef_last
module fir_cmem_seq
  import fir_cmem_pkg::*;
#(
  parameter int NTAPS = NTAPS_DEF,
  parameter int AW    = AW_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic clk,
  input  logic rst,
  fir_cmem_if.slave bus,
  input  logic start,
  input  logic clr_flags,
  output logic busy,
  output logic done,
  output logic overrun
`ifdef W4823_CMEM_PARITY_EN
  ,
  output logic par_err
`endif
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_RUN   = ST_RUN;
  localparam logic [1:0] S_DRAIN = ST_DRAIN;

  localparam logic [AW-1:0] LAST_IDX = AW'(NTAPS - 1);

`ifdef W4823_CMEM_PARITY_EN
  localparam int WW = CW + 1;
`else
  localparam int WW = CW;
`endif

  logic [1:0]    state_d, state_q;
  logic [AW-1:0] ra_d, ra_q;
  logic          valid_d, valid_q;
  logic [AW-1:0] idx_d, idx_q;
  logic          last_d, last_q;
  logic          done_d, done_q;
  logic          ovr_d, ovr_q;
  logic          ovr_set;
  logic          accept;
  logic          re;
  logic [WW-1:0] wr_word;
  logic [WW-1:0] rd_word;

`ifdef W4823_CMEM_PARITY_EN
  assign wr_word = {even_par(32'(bus.cin)), bus.cin};
`else
  assign wr_word = bus.cin;
`endif

  fir_cmem_ram #(
    .DEPTH (NTAPS),
    .AW    (AW),
    .WW    (WW)
  ) u_ram (
    .clk (clk),
    .we  (bus.cload),
    .wa  (bus.caddr),
    .wd  (wr_word),
    .re  (re),
    .ra  (ra_q),
    .rd  (rd_word)
  );

  assign accept = valid_q & bus.coef_ready;

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    last_d  = last_q;
    done_d  = 1'b0;
    re      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The done cycle already shows busy=0, but re-arming waits one more cycle.
        if (start && !done_q) begin
          state_d = S_RUN;
          ra_d    = '0;
        end
      end
      S_RUN: begin
        // Read only when the output register is empty or being emptied this cycle.
        if (!valid_q || bus.coef_ready) begin
          re      = 1'b1;
          valid_d = 1'b1;
          idx_d   = ra_q;
          last_d  = (ra_q == LAST_IDX);
          ra_d    = ra_q + AW'(1);
          if (ra_q == LAST_IDX) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (accept) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ovr_set = start & ((state_q != S_IDLE) | done_q);

  always_comb begin
    ovr_d = ovr_q;
    if (ovr_set)        ovr_d = 1'b1;
    else if (clr_flags) ovr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ra_q    <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef W4823_CMEM_PARITY_EN
  logic chk_d, chk_q;
  logic perr_d, perr_q;

  // A read issued last cycle is sitting in the RAM output register now.
  assign chk_d = re;

  always_comb begin
    perr_d = perr_q;
    if (chk_q && (^rd_word)) perr_d = 1'b1;
    else if (clr_flags)      perr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      chk_q  <= chk_d;
      perr_q <= perr_d;
    end
  end

  assign par_err = perr_q;
`endif

  assign bus.coef_valid = valid_q;
  assign bus.coef_data  = valid_q ? rd_word[CW-1:0] : '0;
  assign bus.coef_idx   = idx_q;
  assign bus.coef_last  = last_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;
  assign overrun        = ovr_q;

endmodule

// File: tb/tb_fir_cmem_seq.sv
// Directed bench for fir_cmem_seq: table of expected taps per load plus hand sequences
// for backpressure, write collision, overrun and mid-sequence reset.
module tb_fir_cmem_seq;
  import fir_cmem_pkg::*;

  localparam int NT = 64;
  localparam int AW = 6;
  localparam int CW = 17;

  logic clk = 1'b0;
  logic rst, start, clr_flags, busy, done, overrun;
`ifdef W4823_CMEM_PARITY_EN
  logic par_err;
`endif

  fir_cmem_if #(.AW(AW), .CW(CW)) bus ();

  fir_cmem_seq #(.NTAPS(NT), .AW(AW), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .start     (start),
    .clr_flags (clr_flags),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
`ifdef W4823_CMEM_PARITY_EN
    ,
    .par_err   (par_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] idx;
    logic [CW-1:0] data;
    logic          last;
  } vec_t;

  vec_t tab [NT];

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW-1:0] got_idx [$];
  logic [CW-1:0] got_dat [$];
  logic          got_lst [$];
  int            first_valid_cyc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [CW-1:0] d);
    bus.cload = 1'b1;
    bus.caddr = AW'(a);
    bus.cin   = d;
    tick;
    bus.cload = 1'b0;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // mode 0: ready=1, 1: ready 1,0,0,1 pattern, 2: overrun pokes, 3: reset at tap 30.
  // inj_cyc >= 0 writes inj_dat to address 10 during that cycle.
  task automatic collect(input int mode, input int inj_cyc, input logic [CW-1:0] inj_dat,
                         output bit aborted);
    int            cyc;
    bit            acc_last, stall_prev, fin, rdy;
    logic [CW-1:0] sd;
    logic [AW-1:0] si;
    logic          sl;
    bit            pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    cyc = 0; acc_last = 0; stall_prev = 0; fin = 0; aborted = 0;
    sd = '0; si = '0; sl = 1'b0;
    got_idx.delete(); got_dat.delete(); got_lst.delete();
    first_valid_cyc = -1;
    while (!fin) begin
      if (cyc >= 400) begin
        chk("stream_timeout", 32'(acc_last), 32'd1);
        break;
      end
      bus.cload = (cyc == inj_cyc);
      bus.caddr = AW'(10);
      bus.cin   = inj_dat;
      rdy = (mode == 1) ? pat[cyc % 4] : 1'b1;
      bus.coef_ready = rdy;
      if (mode == 2) begin
        start     = (cyc == 21) || (cyc == 30);
        clr_flags = (cyc == 22) || (cyc == 30) || (cyc == 32);
        if (cyc == 22) chk("ovr_mid_seq", 32'(overrun), 32'd1);
        if (cyc == 23) chk("ovr_cleared", 32'(overrun), 32'd0);
        if (cyc == 31) chk("ovr_set_wins", 32'(overrun), 32'd1);
        if (cyc == 33) chk("ovr_cleared2", 32'(overrun), 32'd0);
      end
      if (mode == 3 && cyc == 31) begin
        chk("idx_before_rst", 32'(bus.coef_idx), 32'd30);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rst_mid_valid", 32'(bus.coef_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 3; k++) begin
          chk("rst_mid_no_done", 32'(done), 32'd0);
          tick;
        end
        aborted = 1;
        break;
      end
      if (done && !acc_last) chk("early_done", 32'(done), 32'd0);
      if (stall_prev) begin
        chk("stall_data", 32'(bus.coef_data), 32'(sd));
        chk("stall_idx", 32'(bus.coef_idx), 32'(si));
        chk("stall_last", 32'(bus.coef_last), 32'(sl));
      end
      if (bus.coef_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.coef_valid && rdy) begin
        got_idx.push_back(bus.coef_idx);
        got_dat.push_back(bus.coef_data);
        got_lst.push_back(bus.coef_last);
        if (bus.coef_last) acc_last = 1;
      end
      stall_prev = bus.coef_valid && !rdy;
      sd = bus.coef_data; si = bus.coef_idx; sl = bus.coef_last;
      tick;
      cyc++;
      bus.cload = 1'b0;
      if (acc_last) begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_in_done", 32'(busy), 32'd0);
        if (mode == 2) begin
          start = 1'b1;
          tick;
          start = 1'b0;
          chk("ovr_done_cycle", 32'(overrun), 32'd1);
          chk("no_rearm", 32'(busy), 32'd0);
        end else begin
          tick;
          chk("done_one_cycle", 32'(done), 32'd0);
        end
        fin = 1;
      end
    end
    start = 1'b0;
    clr_flags = 1'b0;
    bus.coef_ready = 1'b1;
  endtask

  task automatic verify(input string tag);
    int n;
    chk({tag, "_beats"}, 32'(got_idx.size()), 32'(NT));
    n = (got_idx.size() < NT) ? got_idx.size() : NT;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_idx[%0d]", tag, i), 32'(got_idx[i]), 32'(tab[i].idx));
      chk($sformatf("%s_data[%0d]", tag, i), 32'(got_dat[i]), 32'(tab[i].data));
      chk($sformatf("%s_last[%0d]", tag, i), 32'(got_lst[i]), 32'(tab[i].last));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bit ab;
    for (int i = 0; i < NT; i++) begin
      tab[i].idx  = AW'(i);
      tab[i].data = CW'(i * 3 + 1);
      tab[i].last = (i == NT - 1);
    end
    rst = 1'b1; start = 1'b0; clr_flags = 1'b0;
    bus.cload = 1'b0; bus.caddr = '0; bus.cin = '0; bus.coef_ready = 1'b1;
    tick;

    // Load entirely while held in reset: writes must still land.
    for (int i = 0; i < NT; i++) wr(i, CW'(i * 3 + 1));
    chk("rst_valid", 32'(bus.coef_valid), 32'd0);
    chk("rst_data", 32'(bus.coef_data), 32'd0);
    chk("rst_idx", 32'(bus.coef_idx), 32'd0);
    chk("rst_last", 32'(bus.coef_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    tick;

    // Full-rate stream.
    do_start;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("valid_not_yet", 32'(bus.coef_valid), 32'd0);
    collect(0, -1, '0, ab);
    chk("latency", 32'(first_valid_cyc), 32'd1);
    verify("full");
    tick;

    // Backpressure with ready 1,0,0,1.
    do_start;
    collect(1, -1, '0, ab);
    verify("stall");
    tick;

    // 65 writes: the last wraps onto address 0.
    for (int k = 1; k <= 65; k++)
      wr((k - 1) % NT, (k == 65) ? 17'h1ABCD : CW'(k * 5 + 7));
    tab[0].data = 17'h1ABCD;
    for (int j = 1; j < NT; j++) tab[j].data = CW'((j + 1) * 5 + 7);
    do_start;
    collect(0, -1, '0, ab);
    verify("wrap");
    tick;

    // Write to address 10 in the cycle it is read: old word now, new word next time.
    do_start;
    collect(0, 10, 17'h00055, ab);
    verify("collide_old");
    tab[10].data = 17'h00055;
    tick;
    do_start;
    collect(0, -1, '0, ab);
    verify("collide_new");
    tick;

    // Overrun: start mid-stream, clear, set-wins, and start in the done cycle.
    do_start;
    collect(2, -1, '0, ab);
    verify("ovr");
    tick;
    chk("ovr_idle_busy", 32'(busy), 32'd0);
    clr_flags = 1'b1;
    tick;
    clr_flags = 1'b0;
    chk("ovr_final_clear", 32'(overrun), 32'd0);

    // Reset at tap 30, then confirm memory retained.
    do_start;
    collect(3, -1, '0, ab);
    chk("rst_aborted", 32'(ab), 32'd1);
    do_start;
    collect(0, -1, '0, ab);
    verify("post_rst");

`ifdef W4823_CMEM_PARITY_EN
    chk("par_err_clean", 32'(par_err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
